// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready command port into
// AW/W/B or AR/R transactions and returns the response on a valid/ready port.
module axi4lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      A_CLK,
  input  logic                      A_RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      RSP_WRITE,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic                      AW_VALID,
  input  logic                      AW_READY,
  output logic [ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                AW_PROT,
  output logic                      W_VALID,
  input  logic                      W_READY,
  output logic [DATA_WIDTH-1:0]     W_DATA,
  output logic [DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                      B_VALID,
  output logic                      B_READY,
  input  logic [1:0]                B_RESP,
  output logic                      AR_VALID,
  input  logic                      AR_READY,
  output logic [ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [2:0]                AR_PROT,
  input  logic                      R_VALID,
  output logic                      R_READY,
  input  logic [DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                R_RESP
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                  state, state_n;
  logic                    aw_done, w_done, aw_done_n, w_done_n;
  logic                    cmd_ready_n, aw_valid_n, w_valid_n, b_ready_n;
  logic                    ar_valid_n, r_ready_n, rsp_valid_n, rsp_write_n;
  logic [ADDR_WIDTH-1:0]   aw_addr_n, ar_addr_n;
  logic [DATA_WIDTH-1:0]   w_data_n, rsp_rdata_n;
  logic [STRB_W-1:0]       w_strb_n;
  logic [1:0]              rsp_resp_n;

  assign AW_PROT = '0;
  assign AR_PROT = '0;

  // Every output is a register; the comb block computes its next value so
  // each handshake is reflected on the following edge.
  always_comb begin
    state_n     = state;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    cmd_ready_n = CMD_READY;
    aw_valid_n  = AW_VALID;
    aw_addr_n   = AW_ADDR;
    w_valid_n   = W_VALID;
    w_data_n    = W_DATA;
    w_strb_n    = W_STRB;
    b_ready_n   = B_READY;
    ar_valid_n  = AR_VALID;
    ar_addr_n   = AR_ADDR;
    r_ready_n   = R_READY;
    rsp_valid_n = RSP_VALID;
    rsp_write_n = RSP_WRITE;
    rsp_rdata_n = RSP_RDATA;
    rsp_resp_n  = RSP_RESP;

    unique case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (CMD_VALID && CMD_READY) begin
          cmd_ready_n = 1'b0;
          aw_done_n   = 1'b0;
          w_done_n    = 1'b0;
          if (CMD_WRITE) begin
            state_n    = WR_REQ;
            aw_valid_n = 1'b1;
            aw_addr_n  = CMD_ADDR;
            w_valid_n  = 1'b1;
            w_data_n   = CMD_WDATA;
            w_strb_n   = CMD_WSTRB;
          end else begin
            state_n    = RD_REQ;
            ar_valid_n = 1'b1;
            ar_addr_n  = CMD_ADDR;
          end
        end
      end
      WR_REQ: begin
        if (AW_VALID && AW_READY) begin
          aw_valid_n = 1'b0;
          aw_done_n  = 1'b1;
        end
        if (W_VALID && W_READY) begin
          w_valid_n = 1'b0;
          w_done_n  = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          state_n   = WR_RESP;
          b_ready_n = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      WR_RESP: begin
        if (B_VALID && B_READY) begin
          state_n     = RSP;
          b_ready_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_write_n = 1'b1;
          rsp_rdata_n = '0;
          rsp_resp_n  = B_RESP;
        end
      end
      RD_REQ: begin
        if (AR_VALID && AR_READY) begin
          state_n    = RD_DATA;
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
        end
      end
      RD_DATA: begin
        if (R_VALID && R_READY) begin
          state_n     = RSP;
          r_ready_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_write_n = 1'b0;
          rsp_rdata_n = R_DATA;
          rsp_resp_n  = R_RESP;
        end
      end
      RSP: begin
        if (RSP_VALID && RSP_READY) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      CMD_READY <= 1'b0;
      AW_VALID  <= 1'b0;
      AW_ADDR   <= '0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      W_STRB    <= '0;
      B_READY   <= 1'b0;
      AR_VALID  <= 1'b0;
      AR_ADDR   <= '0;
      R_READY   <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= '0;
    end else begin
      state     <= state_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      CMD_READY <= cmd_ready_n;
      AW_VALID  <= aw_valid_n;
      AW_ADDR   <= aw_addr_n;
      W_VALID   <= w_valid_n;
      W_DATA    <= w_data_n;
      W_STRB    <= w_strb_n;
      B_READY   <= b_ready_n;
      AR_VALID  <= ar_valid_n;
      AR_ADDR   <= ar_addr_n;
      R_READY   <= r_ready_n;
      RSP_VALID <= rsp_valid_n;
      RSP_WRITE <= rsp_write_n;
      RSP_RDATA <= rsp_rdata_n;
      RSP_RESP  <= rsp_resp_n;
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: the bench plays both the command source
// and the AXI4-Lite slave, checking cycle-exact outputs against hand values.
module tb_axi4lite_master;

  logic        A_CLK = 1'b0;
  logic        A_RST = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
  logic [3:0]  CMD_WSTRB = '0;
  logic        RSP_VALID, RSP_READY = 1'b0, RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic        AW_VALID, AW_READY = 1'b0;
  logic [31:0] AW_ADDR;
  logic [2:0]  AW_PROT, AR_PROT;
  logic        W_VALID, W_READY = 1'b0;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID = 1'b0, B_READY;
  logic [1:0]  B_RESP = '0;
  logic        AR_VALID, AR_READY = 1'b0;
  logic [31:0] AR_ADDR;
  logic        R_VALID = 1'b0, R_READY;
  logic [31:0] R_DATA = '0;
  logic [1:0]  R_RESP = '0;

  int total = 0;
  int bad   = 0;

  always #5 A_CLK = ~A_CLK;

  axi4lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  // Waits (bounded) for CMD_READY, then presents one command for exactly one
  // edge; returns #1 after that edge, i.e. in cycle 1 of the transaction.
  task automatic start_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_timeout got=%b exp=1", CMD_READY);
    end
    CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = data; CMD_WSTRB = strb;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    A_RST = 1'b1;
    repeat (3) tick();
    total++;
    if ({CMD_READY, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, RSP_VALID, RSP_WRITE} !== 8'h00) begin
      bad++;
      $display("FAIL rst_handshakes got=%b exp=00000000",
               {CMD_READY, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, RSP_VALID, RSP_WRITE});
    end
    total++;
    if ({AW_ADDR, AR_ADDR, W_DATA, W_STRB, RSP_RDATA, RSP_RESP, AW_PROT, AR_PROT} !== '0) begin
      bad++;
      $display("FAIL rst_payload got=%h/%h/%h/%h/%h/%h exp=0", AW_ADDR, AR_ADDR, W_DATA, W_STRB, RSP_RDATA, RSP_RESP);
    end
    A_RST = 1'b0;
    #1;
    total++;
    if (CMD_READY !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b exp=0", CMD_READY); end
    tick();
    total++;
    if (CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_first_edge_ready got=%b exp=1", CMD_READY); end
  endtask

  task automatic test_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] bresp);
    AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = bresp;
    start_cmd(1'b1, addr, data, strb);
    // cycle 1
    total++;
    if ({AW_VALID, W_VALID, CMD_READY, B_READY} !== 4'b1100) begin
      bad++; $display("FAIL wr_c1_valids got=%b exp=1100", {AW_VALID, W_VALID, CMD_READY, B_READY});
    end
    total++;
    if (AW_ADDR !== addr || W_DATA !== data || W_STRB !== strb) begin
      bad++; $display("FAIL wr_c1_payload got=%h/%h/%h exp=%h/%h/%h", AW_ADDR, W_DATA, W_STRB, addr, data, strb);
    end
    tick();
    // cycle 2
    total++;
    if ({AW_VALID, W_VALID, B_READY, RSP_VALID} !== 4'b0010) begin
      bad++; $display("FAIL wr_c2 got=%b exp=0010", {AW_VALID, W_VALID, B_READY, RSP_VALID});
    end
    tick();
    // cycle 3
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
    total++;
    if ({RSP_VALID, B_READY, RSP_WRITE} !== 3'b101) begin
      bad++; $display("FAIL wr_c3_rsp got=%b exp=101", {RSP_VALID, B_READY, RSP_WRITE});
    end
    total++;
    if (RSP_RESP !== bresp || RSP_RDATA !== 32'h0) begin
      bad++; $display("FAIL wr_c3_resp got=%h/%h exp=%h/0", RSP_RESP, RSP_RDATA, bresp);
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    total++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      bad++; $display("FAIL wr_c4_idle got=%b exp=01", {RSP_VALID, CMD_READY});
    end
  endtask

  task automatic test_read(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp);
    AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = rdata; R_RESP = rresp;
    start_cmd(1'b0, addr, 32'hFFFF_FFFF, 4'hF);
    total++;
    if ({AR_VALID, AW_VALID, W_VALID, CMD_READY} !== 4'b1000 || AR_ADDR !== addr) begin
      bad++; $display("FAIL rd_c1 got=%b/%h exp=1000/%h", {AR_VALID, AW_VALID, W_VALID, CMD_READY}, AR_ADDR, addr);
    end
    tick();
    total++;
    if ({AR_VALID, R_READY, RSP_VALID} !== 3'b010) begin
      bad++; $display("FAIL rd_c2 got=%b exp=010", {AR_VALID, R_READY, RSP_VALID});
    end
    tick();
    AR_READY = 1'b0; R_VALID = 1'b0;
    total++;
    if ({RSP_VALID, R_READY, RSP_WRITE} !== 3'b100) begin
      bad++; $display("FAIL rd_c3_flags got=%b exp=100", {RSP_VALID, R_READY, RSP_WRITE});
    end
    total++;
    if (RSP_RDATA !== rdata || RSP_RESP !== rresp) begin
      bad++; $display("FAIL rd_c3_data got=%h/%h exp=%h/%h", RSP_RDATA, RSP_RESP, rdata, rresp);
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    total++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      bad++; $display("FAIL rd_c4_idle got=%b exp=01", {RSP_VALID, CMD_READY});
    end
  endtask

  task automatic test_skewed_write();
    W_READY = 1'b1; AW_READY = 1'b0; B_VALID = 1'b0;
    start_cmd(1'b1, 32'h44, 32'h1234_5678, 4'h3);
    for (int c = 1; c <= 6; c++) begin
      total++;
      if (AW_VALID !== 1'b1 || AW_ADDR !== 32'h44 || B_READY !== 1'b0 || W_VALID !== (c == 1)) begin
        bad++;
        $display("FAIL skew_cycle%0d aw=%b addr=%h w=%b b_ready=%b exp aw=1 addr=44 w=%b b_ready=0",
                 c, AW_VALID, AW_ADDR, W_VALID, B_READY, (c == 1));
      end
      if (c == 6) AW_READY = 1'b1;
      tick();
    end
    AW_READY = 1'b0; W_READY = 1'b0;
    total++;
    if ({AW_VALID, W_VALID, B_READY} !== 3'b001) begin
      bad++; $display("FAIL skew_c7 got=%b exp=001", {AW_VALID, W_VALID, B_READY});
    end
    B_VALID = 1'b1; B_RESP = 2'b00;
    tick();
    B_VALID = 1'b0;
    total++;
    if ({RSP_VALID, RSP_WRITE, RSP_RESP} !== 4'b1100) begin
      bad++; $display("FAIL skew_rsp got=%b exp=1100", {RSP_VALID, RSP_WRITE, RSP_RESP});
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    total++;
    if (CMD_READY !== 1'b1) begin bad++; $display("FAIL skew_cmd_ready got=%b exp=1", CMD_READY); end
  endtask

  task automatic test_backpressure();
    AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 32'hA5A5_0F0F; R_RESP = 2'b01;
    start_cmd(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    tick();
    AR_READY = 1'b0; R_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hA5A5_0F0F || RSP_RESP !== 2'b01 ||
          RSP_WRITE !== 1'b0 || CMD_READY !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b d=%h r=%h w=%b cr=%b exp v=1 d=a5a50f0f r=1 w=0 cr=0",
                 i, RSP_VALID, RSP_RDATA, RSP_RESP, RSP_WRITE, CMD_READY);
      end
      if (i == 4) RSP_READY = 1'b1;
      tick();
    end
    RSP_READY = 1'b0;
    total++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      bad++; $display("FAIL bp_release got=%b exp=01", {RSP_VALID, CMD_READY});
    end
  endtask

  task automatic test_errors();
    test_write(32'h100, 32'h0000_0001, 4'h1, 2'b10);
    test_read(32'h104, 32'h0BAD_F00D, 2'b11);
  endtask

  task automatic test_reset_midflight();
    AW_READY = 1'b0; W_READY = 1'b0;
    start_cmd(1'b1, 32'h200, 32'h7777_7777, 4'hF);
    total++;
    if ({AW_VALID, W_VALID} !== 2'b11) begin
      bad++; $display("FAIL mid_pre got=%b exp=11", {AW_VALID, W_VALID});
    end
    #3 A_RST = 1'b1;
    #1;
    total++;
    if ({AW_VALID, W_VALID, CMD_READY} !== 3'b000 || AW_ADDR !== 32'h0 || W_DATA !== 32'h0) begin
      bad++; $display("FAIL mid_async_clear got=%b/%h/%h exp=000/0/0", {AW_VALID, W_VALID, CMD_READY}, AW_ADDR, W_DATA);
    end
    tick();
    tick();
    A_RST = 1'b0;
    test_read(32'h300, 32'h55AA_55AA, 2'b00);
  endtask

  initial begin
    test_reset();
    test_write(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
    test_read(32'h20, 32'hCAFE_F00D, 2'b00);
    test_skewed_write();
    test_backpressure();
    test_errors();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
